// File: rtl/gpi_poll_ctrl.sv
// gpi_poll_ctrl: APB master that programs the GPI control register, then polls the input
// data register, keeping the last sample, sticky rise/fall flags and a level irq.
// Optional read debounce: define GPI_DEBOUNCE_EN.
module gpi_poll_ctrl #(
   parameter int unsigned POLL_DIV = 1000,
   parameter logic [2:0]  CR_ADDR  = 3'h0,
   parameter logic [2:0]  IDR_ADDR = 3'h4,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic        en,
   input  logic [7:0]  cr_cfg,
   input  logic        irq_clr,
   output logic [2:0]  PADDR,
   output logic        PSEL,
   output logic        PENABLE,
   output logic        PWRITE,
   output logic [31:0] PWDATA,
   input  logic [31:0] PRDATA,
   input  logic        PREADY,
   output logic [7:0]  sample,
   output logic        sample_valid,
   output logic [7:0]  rise,
   output logic [7:0]  fall,
   output logic        irq,
   output logic        busy,
   output logic        timeout_err
);

   localparam int unsigned CNT_W = 16;
   localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] POLL_RELOAD = CNT_W'(POLL_DIV - 1);
   localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_CFG_SETUP  = 3'd1,
      S_CFG_ACCESS = 3'd2,
      S_WAIT       = 3'd3,
      S_RD_SETUP   = 3'd4,
      S_RD_ACCESS  = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  poll_cnt_q, poll_cnt_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic [7:0]        cr_shadow_q, cr_shadow_d;
   logic [7:0]        sample_q, sample_d;
   logic [7:0]        rise_q, rise_d;
   logic [7:0]        fall_q, fall_d;
   logic              cfg_pend_q, cfg_pend_d;
   logic              prev_valid_q, prev_valid_d;
   logic              sample_valid_q, sample_valid_d;
   logic              timeout_err_q, timeout_err_d;
   logic              busy_q, busy_d;
   logic              psel_q, psel_d;
   logic              penable_q, penable_d;
   logic              pwrite_q, pwrite_d;
   logic [2:0]        paddr_q, paddr_d;
   logic [31:0]       pwdata_q, pwdata_d;
`ifdef GPI_DEBOUNCE_EN
   logic [7:0]        raw_prev_q, raw_prev_d;
   logic              raw_valid_q, raw_valid_d;
`endif

   logic       in_access;
   logic       xfer_done;
   logic       xfer_abort;
   logic       xfer_end;
   logic       cfg_change;
   logic       poll_zero;
   logic       rd_done;
   logic       rd_accept;
   logic [7:0] rd_new;
   logic       unused_prdata;

   // Transfer events; PREADY high in the last allowed cycle still counts as completion
   assign in_access  = (state_q == S_CFG_ACCESS) || (state_q == S_RD_ACCESS);
   assign xfer_done  = in_access && PREADY;
   assign xfer_abort = in_access && !PREADY && (to_cnt_q == TO_LAST);
   assign xfer_end   = xfer_done || xfer_abort;
   assign cfg_change = (cr_cfg != cr_shadow_q);
   assign poll_zero  = (poll_cnt_q == '0);
   assign rd_done    = (state_q == S_RD_ACCESS) && PREADY;
   assign rd_new     = PRDATA[7:0] & cr_shadow_q;
   assign unused_prdata = ^PRDATA[31:8];

`ifdef GPI_DEBOUNCE_EN
   assign rd_accept = rd_done && raw_valid_q && (rd_new == raw_prev_q);
`else
   assign rd_accept = rd_done;
`endif

   always_ff @(posedge PCLK or posedge PRESET) begin : state_reg
      if (PRESET) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin : next_state_comb
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (en) state_d = S_CFG_SETUP;
         end
         S_CFG_SETUP: state_d = S_CFG_ACCESS;
         S_RD_SETUP:  state_d = S_RD_ACCESS;
         S_CFG_ACCESS, S_RD_ACCESS: begin
            if (xfer_end) state_d = en ? S_WAIT : S_IDLE;
         end
         S_WAIT: begin
            // a CR change or a pending (timed-out) CFG takes precedence over the next read
            if (!en) begin
               state_d = S_IDLE;
            end else if (cfg_change || (poll_zero && cfg_pend_q)) begin
               state_d = S_CFG_SETUP;
            end else if (poll_zero) begin
               state_d = S_RD_SETUP;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin : output_comb
      cr_shadow_d    = cr_shadow_q;
      paddr_d        = paddr_q;
      pwrite_d       = pwrite_q;
      pwdata_d       = pwdata_q;
      poll_cnt_d     = poll_cnt_q;
      to_cnt_d       = to_cnt_q;
      cfg_pend_d     = cfg_pend_q;
      prev_valid_d   = prev_valid_q;
      sample_d       = sample_q;
      sample_valid_d = 1'b0;
      rise_d         = irq_clr ? 8'h00 : rise_q;
      fall_d         = irq_clr ? 8'h00 : fall_q;
      timeout_err_d  = (irq_clr ? 1'b0 : timeout_err_q) | xfer_abort;
      busy_d         = (state_d != S_IDLE);
      psel_d         = (state_d inside {S_CFG_SETUP, S_CFG_ACCESS, S_RD_SETUP, S_RD_ACCESS});
      penable_d      = (state_d inside {S_CFG_ACCESS, S_RD_ACCESS});
`ifdef GPI_DEBOUNCE_EN
      raw_prev_d     = raw_prev_q;
      raw_valid_d    = raw_valid_q;
`endif

      // Address/data are launched with SETUP and held through ACCESS
      if (state_d == S_CFG_SETUP) begin
         cr_shadow_d = cr_cfg;
         paddr_d     = CR_ADDR;
         pwrite_d    = 1'b1;
         pwdata_d    = {24'h000000, cr_cfg};
      end else if (state_d == S_RD_SETUP) begin
         paddr_d  = IDR_ADDR;
         pwrite_d = 1'b0;
      end

      if (state_q inside {S_CFG_SETUP, S_RD_SETUP}) begin
         to_cnt_d = '0;
      end else if (in_access) begin
         to_cnt_d = to_cnt_q + TO_W'(1);
      end

      if (xfer_end) begin
         poll_cnt_d = POLL_RELOAD;
      end else if ((state_q == S_WAIT) && !poll_zero) begin
         poll_cnt_d = poll_cnt_q - CNT_W'(1);
      end

      if (state_q == S_CFG_ACCESS) begin
         if (PREADY) begin
            cfg_pend_d   = 1'b0;
            prev_valid_d = 1'b0;
`ifdef GPI_DEBOUNCE_EN
            raw_valid_d  = 1'b0;
`endif
         end else if (xfer_abort) begin
            cfg_pend_d = 1'b1;
         end
      end

`ifdef GPI_DEBOUNCE_EN
      if (rd_done) begin
         raw_prev_d  = rd_new;
         raw_valid_d = 1'b1;
      end
`endif

      // Edge flags only compare against a sample taken under the same CR
      if (rd_accept) begin
         if (prev_valid_q) begin
            rise_d = rise_d | (rd_new & ~sample_q);
            fall_d = fall_d | (~rd_new & sample_q);
         end
         sample_d       = rd_new;
         sample_valid_d = 1'b1;
         prev_valid_d   = 1'b1;
      end
   end

   always_ff @(posedge PCLK or posedge PRESET) begin : data_reg
      if (PRESET) begin
         poll_cnt_q     <= '0;
         to_cnt_q       <= '0;
         cr_shadow_q    <= 8'h00;
         sample_q       <= 8'h00;
         rise_q         <= 8'h00;
         fall_q         <= 8'h00;
         cfg_pend_q     <= 1'b0;
         prev_valid_q   <= 1'b0;
         sample_valid_q <= 1'b0;
         timeout_err_q  <= 1'b0;
         busy_q         <= 1'b0;
         psel_q         <= 1'b0;
         penable_q      <= 1'b0;
         pwrite_q       <= 1'b0;
         paddr_q        <= 3'h0;
         pwdata_q       <= 32'h0;
      end else begin
         poll_cnt_q     <= poll_cnt_d;
         to_cnt_q       <= to_cnt_d;
         cr_shadow_q    <= cr_shadow_d;
         sample_q       <= sample_d;
         rise_q         <= rise_d;
         fall_q         <= fall_d;
         cfg_pend_q     <= cfg_pend_d;
         prev_valid_q   <= prev_valid_d;
         sample_valid_q <= sample_valid_d;
         timeout_err_q  <= timeout_err_d;
         busy_q         <= busy_d;
         psel_q         <= psel_d;
         penable_q      <= penable_d;
         pwrite_q       <= pwrite_d;
         paddr_q        <= paddr_d;
         pwdata_q       <= pwdata_d;
      end
   end

`ifdef GPI_DEBOUNCE_EN
   always_ff @(posedge PCLK or posedge PRESET) begin : debounce_reg
      if (PRESET) begin
         raw_prev_q  <= 8'h00;
         raw_valid_q <= 1'b0;
      end else begin
         raw_prev_q  <= raw_prev_d;
         raw_valid_q <= raw_valid_d;
      end
   end
`endif

   assign PADDR        = paddr_q;
   assign PSEL         = psel_q;
   assign PENABLE      = penable_q;
   assign PWRITE       = pwrite_q;
   assign PWDATA       = pwdata_q;
   assign sample       = sample_q;
   assign sample_valid = sample_valid_q;
   assign rise         = rise_q;
   assign fall         = fall_q;
   assign busy         = busy_q;
   assign timeout_err  = timeout_err_q;
   assign irq          = (|(rise_q | fall_q)) | timeout_err_q;

endmodule
